sync_byte_framer: RTL and testbench
===================================

// Module: sync_byte_framer
// PURPOSE
//   Downstream consumer of the serial bit stream isenal that feeds the 8-bit vector store.
//   Hunts for a sync byte in the stream and locks byte alignment to it.
//   Once locked, emits each payload byte with a one-cycle valid strobe.
//   Checks the sync byte at every frame boundary and drops lock after repeated misses.
//   Frame format: SYNC_WORD, then N_DATA payload bytes, repeating; MSB first, one bit per iclk.
// PARAMETERS
//   SYNC_WORD  8'hA5  frame alignment pattern
//   N_DATA     4      payload bytes per frame (1..255)
//   MAX_MISS   2      consecutive bad sync slots that force loss of lock (1..15)
// PORTS
//   iclk      in   1  clock; all state updates on the rising edge
//   irst      in   1  reset, asynchronous, active-high
//   isenal    in   1  serial data bit, sampled on every iclk rising edge
//   odato     out  8  last payload byte; holds its value between strobes
//   ovalido   out  1  one-cycle pulse: odato updated this cycle
//   obloqueo  out  1  1 = frame alignment locked
//   oerror    out  1  one-cycle pulse: sync slot mismatch while locked
// BEHAVIOUR
//   - Reset: on irst=1, immediately (not at the next edge) set state=HUNT.
//     Clear sr, bit_cnt, byte_cnt, miss_cnt. Outputs: odato=8'h00, ovalido=0, obloqueo=0, oerror=0.
//     Reset mid-frame discards the partial byte; no strobe is produced for it.
//   - Shift register: sr[7:0] <= {sr[6:0], isenal} every edge.
//     nxt = {sr[6:0], isenal} is the byte completed at this edge.
//   - ovalido and oerror are registered. They go high for exactly one cycle after the edge that samples the 8th bit.
//     Latency from last bit sampled to strobe visible is 1 edge.
//   - HUNT: obloqueo=0. Every edge, compare nxt with SYNC_WORD. This is a bit-by-bit sliding match.
//     On a match: go to LOCKED, bit_cnt=0, byte_cnt=0, miss_cnt=0, obloqueo<=1.
//     Nothing is emitted in HUNT.
//   - LOCKED: bit_cnt counts 0..7 and wraps.
//     Action is taken only at an edge where bit_cnt==7 (byte boundary):
//     * byte_cnt < N_DATA: odato<=nxt, ovalido<=1, byte_cnt++. Payload equal to SYNC_WORD is ordinary data; no realignment.
//     * byte_cnt == N_DATA (sync slot), nxt == SYNC_WORD: miss_cnt=0, byte_cnt=0.
//     * sync slot, nxt != SYNC_WORD: oerror<=1, miss_cnt++.
//       If the new miss_cnt == MAX_MISS: go to HUNT, obloqueo<=0, counters clear.
//       Otherwise stay LOCKED, treat the slot as sync (byte_cnt=0), keep the bit alignment.
//   - Losing lock does not clear odato.
//   - On the transition LOCKED->HUNT, hunting starts with the next edge. sr is not cleared.
//     A sync pattern overlapping the bad slot can therefore relock within 8 edges.
//   - Counter widths: bit_cnt 3b. byte_cnt sized for N_DATA. miss_cnt 4b, saturating logic not needed because it is bounded by MAX_MISS.
//   - State encoding is a 1-bit state register (HUNT=0, LOCKED=1). Combinational next-state logic, registered outputs only.
// TESTING  (SYNC_WORD=8'hA5, N_DATA=2, MAX_MISS=2, iclk period 100)
//   1 Lock and emit: irst pulse, send 0,1,1 noise, then A5,3C,C3,A5,5A,0F.
//     -> obloqueo=1 one edge after the last A5 bit.
//     -> ovalido pulses carry 3C, C3, 5A, 0F. oerror stays 0.
//   2 No false lock: send 7 bits 1010010 then 0,0,0,0.
//     -> obloqueo stays 0 and ovalido never pulses.
//   3 Payload A5: frame A5,A5,11,A5.
//     -> odato strobes A5 then 11. Alignment unchanged; next sync accepted.
//   4 Single miss: locked, frame A5,12,34,00,56,78,A5.
//     -> oerror pulses once at the 00 slot. obloqueo stays 1; 56 and 78 are strobed.
//     -> The following A5 clears the miss count (verify by a later single miss not unlocking).
//   5 Loss of lock: locked, two consecutive sync slots = FF.
//     -> oerror pulses twice. obloqueo falls at the second one.
//     -> No further ovalido until a new A5 is seen.
//   6 Async reset mid-byte: locked, assert irst between edges after 4 payload bits.
//     -> all outputs 0 before the next edge, state HUNT.
//     -> Relocks on the next A5 only.

Source files
------------

// File: rtl/sync_byte_framer.sv
// Serial sync-byte framer: hunts for SYNC_WORD bit by bit, then locks byte alignment,
// strobes out payload bytes and drops lock after MAX_MISS consecutive bad sync slots.
module sync_byte_framer #(
    parameter logic [7:0]  SYNC_WORD = 8'hA5,
    parameter int unsigned N_DATA    = 4,
    parameter int unsigned MAX_MISS  = 2
) (
    input  logic       iclk,
    input  logic       irst,
    input  logic       isenal,
    output logic [7:0] odato,
    output logic       ovalido,
    output logic       obloqueo,
    output logic       oerror
);

    localparam int unsigned      BW         = $clog2(N_DATA + 1);
    localparam logic [BW-1:0]    LAST_BYTE  = BW'(N_DATA);
    localparam logic [3:0]       MISS_LIMIT = 4'(MAX_MISS);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    sr_q, sr_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [BW-1:0] byte_cnt_q, byte_cnt_d;
    logic [3:0]    miss_cnt_q, miss_cnt_d;
    logic [7:0]    odato_q, odato_d;
    logic          ovalido_q, ovalido_d;
    logic          obloqueo_q, obloqueo_d;
    logic          oerror_q, oerror_d;
    logic [7:0]    nxt;

    assign nxt = {sr_q[6:0], isenal};

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        sr_d       = nxt;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        miss_cnt_d = miss_cnt_q;
        odato_d    = odato_q;
        ovalido_d  = 1'b0;
        obloqueo_d = obloqueo_q;
        oerror_d   = 1'b0;

        unique case (state_q)
            HUNT: begin
                obloqueo_d = 1'b0;
                if (nxt == SYNC_WORD) begin
                    state_d    = LOCKED;
                    bit_cnt_d  = 3'd0;
                    byte_cnt_d = '0;
                    miss_cnt_d = 4'd0;
                    obloqueo_d = 1'b1;
                end
            end
            LOCKED: begin
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    if (byte_cnt_q < LAST_BYTE) begin
                        odato_d    = nxt;
                        ovalido_d  = 1'b1;
                        byte_cnt_d = byte_cnt_q + BW'(1);
                    end else if (nxt == SYNC_WORD) begin
                        miss_cnt_d = 4'd0;
                        byte_cnt_d = '0;
                    end else begin
                        // A bad sync slot still counts as the frame boundary unless lock is lost.
                        oerror_d   = 1'b1;
                        miss_cnt_d = miss_cnt_q + 4'd1;
                        byte_cnt_d = '0;
                        if (miss_cnt_q + 4'd1 == MISS_LIMIT) begin
                            state_d    = HUNT;
                            obloqueo_d = 1'b0;
                            bit_cnt_d  = 3'd0;
                            miss_cnt_d = 4'd0;
                        end
                    end
                end
            end
            default: state_d = HUNT;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            state_q    <= HUNT;
            sr_q       <= 8'h00;
            bit_cnt_q  <= 3'd0;
            byte_cnt_q <= '0;
            miss_cnt_q <= 4'd0;
            odato_q    <= 8'h00;
            ovalido_q  <= 1'b0;
            obloqueo_q <= 1'b0;
            oerror_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            odato_q    <= odato_d;
            ovalido_q  <= ovalido_d;
            obloqueo_q <= obloqueo_d;
            oerror_q   <= oerror_d;
        end
    end

    assign odato    = odato_q;
    assign ovalido  = ovalido_q;
    assign obloqueo = obloqueo_q;
    assign oerror   = oerror_q;

endmodule

// File: tb/tb_sync_byte_framer.sv
// Bench for sync_byte_framer: byte-level vector table with a payload scoreboard,
// plus hand-written sequences for false-lock and asynchronous reset corner cases.
module tb_sync_byte_framer;

    logic       iclk = 1'b0;
    logic       irst = 1'b0;
    logic       isenal = 1'b0;
    logic [7:0] odato;
    logic       ovalido;
    logic       obloqueo;
    logic       oerror;

    int total = 0;
    int bad   = 0;
    int err_seen = 0;
    int err_expected = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] b;
        logic       exp_val;
        logic       exp_err;
        logic       exp_lock;
    } vec_t;

    vec_t vecs[$];

    sync_byte_framer #(
        .SYNC_WORD(8'hA5),
        .N_DATA   (2),
        .MAX_MISS (2)
    ) dut (
        .iclk    (iclk),
        .irst    (irst),
        .isenal  (isenal),
        .odato   (odato),
        .ovalido (ovalido),
        .obloqueo(obloqueo),
        .oerror  (oerror)
    );

    always #50 iclk = ~iclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Payload scoreboard and error pulse counter, sampled on the falling edge.
    always @(negedge iclk) begin
        if (ovalido === 1'b1) begin
            check("sb_queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("sb_odato", 32'(odato), 32'(exp_q.pop_front()));
        end
        if (oerror === 1'b1) err_seen++;
    end

    task automatic send_bit(input logic b);
        isenal = b;
        @(posedge iclk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic do_reset();
        isenal = 1'b0;
        irst   = 1'b1;
        #1;
        check("rst_odato", 32'(odato), 32'h00);
        check("rst_ovalido", 32'(ovalido), 32'd0);
        check("rst_obloqueo", 32'(obloqueo), 32'd0);
        check("rst_oerror", 32'(oerror), 32'd0);
        @(negedge iclk);
        #2;
        irst = 1'b0;
        @(posedge iclk);
        #1;
    endtask

    task automatic add(input logic [7:0] b, input logic v, input logic e, input logic l);
        vec_t t;
        t.b = b; t.exp_val = v; t.exp_err = e; t.exp_lock = l;
        vecs.push_back(t);
    endtask

    task automatic run_vec(input vec_t v);
        if (v.exp_val) exp_q.push_back(v.b);
        if (v.exp_err) err_expected++;
        send_byte(v.b);
        check("vec_ovalido", 32'(ovalido), 32'(v.exp_val));
        check("vec_oerror", 32'(oerror), 32'(v.exp_err));
        check("vec_obloqueo", 32'(obloqueo), 32'(v.exp_lock));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] false_bits;
        #5;
        do_reset();

        // No false lock on a 7-bit partial pattern followed by zeros.
        false_bits = 11'b1010010_0000;
        for (int i = 10; i >= 0; i--) begin
            send_bit(false_bits[i]);
            check("nolock_obloqueo", 32'(obloqueo), 32'd0);
        end

        do_reset();
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        check("noise_obloqueo", 32'(obloqueo), 32'd0);

        // Lock and emit.
        add(8'hA5, 0, 0, 1); add(8'h3C, 1, 0, 1); add(8'hC3, 1, 0, 1);
        add(8'hA5, 0, 0, 1); add(8'h5A, 1, 0, 1); add(8'h0F, 1, 0, 1);
        // Payload equal to the sync word is plain data.
        add(8'hA5, 0, 0, 1); add(8'hA5, 1, 0, 1); add(8'h11, 1, 0, 1);
        add(8'hA5, 0, 0, 1);
        // Single miss, then a good sync clears the miss count.
        add(8'h12, 1, 0, 1); add(8'h34, 1, 0, 1); add(8'h00, 0, 1, 1);
        add(8'h56, 1, 0, 1); add(8'h78, 1, 0, 1); add(8'hA5, 0, 0, 1);
        add(8'h9A, 1, 0, 1); add(8'hBC, 1, 0, 1); add(8'hFF, 0, 1, 1);
        add(8'h01, 1, 0, 1); add(8'h02, 1, 0, 1); add(8'hA5, 0, 0, 1);
        // Two consecutive misses drop lock; silence until a new sync.
        add(8'h03, 1, 0, 1); add(8'h04, 1, 0, 1); add(8'hFF, 0, 1, 1);
        add(8'h05, 1, 0, 1); add(8'h06, 1, 0, 1); add(8'hFF, 0, 1, 0);
        add(8'h00, 0, 0, 0); add(8'h00, 0, 0, 0);
        add(8'hA5, 0, 0, 1); add(8'h77, 1, 0, 1); add(8'h88, 1, 0, 1);
        add(8'hA5, 0, 0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i]);
            if (i == 27) check("odato_held_after_unlock", 32'(odato), 32'h06);
        end

        // Async reset mid-byte: 4 payload bits in, reset between edges.
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        #20;
        do_reset();
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        send_byte(8'hC3);
        check("after_rst_obloqueo", 32'(obloqueo), 32'd0);
        run_vec('{b: 8'hA5, exp_val: 1'b0, exp_err: 1'b0, exp_lock: 1'b1});
        run_vec('{b: 8'h5A, exp_val: 1'b1, exp_err: 1'b0, exp_lock: 1'b1});
        run_vec('{b: 8'h0F, exp_val: 1'b1, exp_err: 1'b0, exp_lock: 1'b1});

        @(posedge iclk);
        #1;
        check("sb_queue_drained", 32'(exp_q.size()), 32'd0);
        check("oerror_pulse_count", 32'(err_seen), 32'(err_expected));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
